sa_cache_ctrl: RTL and testbench

SA_CACHE_CTRL -- requirements
Module: sa_cache_ctrl

---
 rtl/sa_cache_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_sa_cache_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_ctrl.sv
// rtl/sa_cache_ctrl.sv - set-associative cache tag controller with LRU/FIFO replacement and statistics
module sa_cache_ctrl #(
  parameter int  ADDR_W      = 48,
  parameter int  SETS        = 64,
  parameter int  WAYS        = 4,
  parameter int  BLOCK_BYTES = 64,
  parameter int  CNT_W       = 16,
  localparam int OFF_W       = $clog2(BLOCK_BYTES),
  localparam int IDX_W       = $clog2(SETS),
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_policy,
  input  logic              replace_policy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_writeback,
  output logic              resp_mem_write,
  output logic [TAG_W-1:0]  curr_tag,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes,
  output logic [CNT_W-1:0]  num_read_misses,
  output logic [CNT_W-1:0]  num_write_misses,
  output logic [CNT_W-1:0]  num_hits,
  output logic [CNT_W-1:0]  num_writebacks
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t             state_q, state_d;
  logic               write_q, write_d, wp_q, wp_d, rp_q, rp_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]   curr_tag_q, curr_tag_d;
  logic               hit_q, hit_d, wb_q, wb_d, mw_q, mw_d;
  logic [CNT_W-1:0]   rd_q, rd_d, wr_q, wr_d, rdm_q, rdm_d, wrm_q, wrm_d, hits_q, hits_d, wbs_q, wbs_d;

  // Per-way metadata; age is a recency/fill rank, valid ways always hold distinct ranks 0..k-1
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]   age_q   [SETS][WAYS];

  logic [WAYS-1:0]    set_valid_d, set_dirty_d;
  logic [TAG_W-1:0]   set_tag_d [WAYS];
  logic [WAY_W-1:0]   set_age_d [WAYS];

  logic               hit, inv_found, fill, touch, acc_valid, writeback, mem_write;
  logic [WAY_W-1:0]   hit_way, inv_way, old_way, victim, acc_way, old_age;

  logic               unused_off;
  assign unused_off = ^req_addr[OFF_W-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Tag match, lowest invalid way and oldest-ranked way of the indexed set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx_q][w] && tag_q[idx_q][w] == curr_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[idx_q][w] > age_q[idx_q][old_way]) old_way = WAY_W'(w);
    end
  end

  // Access outcome and next contents of the indexed set
  always_comb begin
    victim    = inv_found ? inv_way : old_way;
    fill      = !hit && (!write_q || !wp_q);
    touch     = hit ? !rp_q : fill;
    acc_way   = hit ? hit_way : victim;
    acc_valid = valid_q[idx_q][acc_way];
    old_age   = age_q[idx_q][acc_way];
    writeback = fill && valid_q[idx_q][victim] && dirty_q[idx_q][victim];
    mem_write = write_q && wp_q;
    set_valid_d = valid_q[idx_q];
    set_dirty_d = dirty_q[idx_q];
    for (int w = 0; w < WAYS; w++) begin
      set_tag_d[w] = tag_q[idx_q][w];
      set_age_d[w] = age_q[idx_q][w];
    end
    if (fill) begin
      set_valid_d[acc_way] = 1'b1;
      set_dirty_d[acc_way] = write_q;
      set_tag_d[acc_way]   = curr_tag_q;
    end
    if (hit && write_q && !wp_q) set_dirty_d[acc_way] = 1'b1;
    if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == acc_way) set_age_d[w] = '0;
        else if (valid_q[idx_q][w] && (!acc_valid || age_q[idx_q][w] < old_age))
          set_age_d[w] = age_q[idx_q][w] + WAY_W'(1);
      end
    end
  end

  // FSM next state, request latch, response flags and statistics
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    wp_d = wp_q;
    rp_d = rp_q;
    idx_d = idx_q;
    curr_tag_d = curr_tag_q;
    hit_d = hit_q;
    wb_d = wb_q;
    mw_d = mw_q;
    rd_d = rd_q;
    wr_d = wr_q;
    rdm_d = rdm_q;
    wrm_d = wrm_q;
    hits_d = hits_q;
    wbs_d = wbs_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d    = req_write;
          wp_d       = write_policy;
          rp_d       = replace_policy;
          idx_d      = req_addr[IDX_W+OFF_W-1:OFF_W];
          curr_tag_d = req_addr[ADDR_W-1:IDX_W+OFF_W];
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = hit;
        wb_d  = writeback;
        mw_d  = mem_write;
        if (write_q) wr_d = sat_inc(wr_q);
        else         rd_d = sat_inc(rd_q);
        if (hit)          hits_d = sat_inc(hits_q);
        else if (write_q) wrm_d  = sat_inc(wrm_q);
        else              rdm_d  = sat_inc(rdm_q);
        if (writeback) wbs_d = sat_inc(wbs_q);
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      idx_q <= '0;
      curr_tag_q <= '0;
      hit_q <= 1'b0;
      wb_q <= 1'b0;
      mw_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      rdm_q <= '0;
      wrm_q <= '0;
      hits_q <= '0;
      wbs_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      idx_q <= idx_d;
      curr_tag_q <= curr_tag_d;
      hit_q <= hit_d;
      wb_q <= wb_d;
      mw_q <= mw_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      rdm_q <= rdm_d;
      wrm_q <= wrm_d;
      hits_q <= hits_d;
      wbs_q <= wbs_d;
    end
  end

  // Metadata storage: written back only on the LOOKUP->RESP edge; tags need no reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else if (state_q == LOOKUP) begin
      valid_q[idx_q] <= set_valid_d;
      dirty_q[idx_q] <= set_dirty_d;
      for (int w = 0; w < WAYS; w++) begin
        tag_q[idx_q][w] <= set_tag_d[w];
        age_q[idx_q][w] <= set_age_d[w];
      end
    end
  end

  assign req_ready        = (state_q == IDLE) && !reset;
  assign resp_valid       = (state_q == RESP) && !reset;
  assign resp_hit         = resp_valid && hit_q;
  assign resp_writeback   = resp_valid && wb_q;
  assign resp_mem_write   = resp_valid && mw_q;
  assign curr_tag         = curr_tag_q;
  assign num_reads        = rd_q;
  assign num_writes       = wr_q;
  assign num_read_misses  = rdm_q;
  assign num_write_misses = wrm_q;
  assign num_hits         = hits_q;
  assign num_writebacks   = wbs_q;

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb/tb_sa_cache_ctrl.sv - directed table-driven bench for sa_cache_ctrl
module tb_sa_cache_ctrl;

  localparam int TW = 36;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic write_policy = 1'b0;
  logic replace_policy = 1'b0;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [47:0] req_addr = '0;

  logic req_ready, resp_valid, resp_hit, resp_writeback, resp_mem_write;
  logic [TW-1:0] curr_tag;
  logic [15:0] num_reads, num_writes, num_read_misses, num_write_misses, num_hits, num_writebacks;

  logic unused_rdy4, unused_rv4, unused_rh4, unused_rwb4, unused_rmw4;
  logic [TW-1:0] unused_tag4;
  logic [3:0] s_reads, s_hits, s_rdm, unused_wr4, unused_wrm4, unused_wbs4;

  sa_cache_ctrl dut (
    .clk(clk), .reset(reset), .write_policy(write_policy), .replace_policy(replace_policy),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_writeback(resp_writeback),
    .resp_mem_write(resp_mem_write), .curr_tag(curr_tag),
    .num_reads(num_reads), .num_writes(num_writes), .num_read_misses(num_read_misses),
    .num_write_misses(num_write_misses), .num_hits(num_hits), .num_writebacks(num_writebacks)
  );

  sa_cache_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .write_policy(write_policy), .replace_policy(replace_policy),
    .req_valid(req_valid), .req_ready(unused_rdy4), .req_write(req_write), .req_addr(req_addr),
    .resp_valid(unused_rv4), .resp_hit(unused_rh4), .resp_writeback(unused_rwb4),
    .resp_mem_write(unused_rmw4), .curr_tag(unused_tag4),
    .num_reads(s_reads), .num_writes(unused_wr4), .num_read_misses(s_rdm),
    .num_write_misses(unused_wrm4), .num_hits(s_hits), .num_writebacks(unused_wbs4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          w;
    logic [47:0] addr;
    bit          wp;
    bit          rp;
    bit          hit;
    bit          wb;
    bit          mw;
  } vec_t;

  vec_t vt[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(input bit rst, input bit w, input logic [47:0] a, input bit wp, input bit rp,
                      input bit hit, input bit wb, input bit mw);
    vec_t v;
    v.rst = rst; v.w = w; v.addr = a; v.wp = wp; v.rp = rp; v.hit = hit; v.wb = wb; v.mw = mw;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
  endtask

  // Issue one request; the policy inputs and address are scrambled right after acceptance
  task automatic issue(input bit w, input logic [47:0] a, input bit wp, input bit rp,
                       output bit hit, output bit wb, output bit mw, output int lat);
    int waited;
    waited = 0;
    hit = 1'b0; wb = 1'b0; mw = 1'b0; lat = 0;
    @(negedge clk);
    while (!req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
      return;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; write_policy = wp; replace_policy = rp;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; write_policy = ~wp; replace_policy = ~rp; req_addr = '1; req_write = ~w;
    for (int n = 1; n <= 6; n++) begin
      if (resp_valid) begin
        lat = n; hit = resp_hit; wb = resp_writeback; mw = resp_mem_write;
        break;
      end
      if (n < 6) @(negedge clk);
    end
  endtask

  task automatic run_vec(input int lo, input int hi);
    bit h, wb, mw;
    int lat;
    for (int i = lo; i <= hi; i++) begin
      if (vt[i].rst) do_reset();
      issue(vt[i].w, vt[i].addr, vt[i].wp, vt[i].rp, h, wb, mw, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("v%0d_hit", i), {63'd0, h}, {63'd0, vt[i].hit});
      chk($sformatf("v%0d_writeback", i), {63'd0, wb}, {63'd0, vt[i].wb});
      chk($sformatf("v%0d_mem_write", i), {63'd0, mw}, {63'd0, vt[i].mw});
    end
  endtask

  initial begin
    bit h, wb, mw;
    int lat;
    // 0..1 : default read pair
    addv(1, 0, 48'h7fff493822b8, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h7fff493822b0, 0, 0, 1, 0, 0);
    // 2..8 : LRU in set 10
    addv(1, 0, 48'h1280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h2280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h3280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h4280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h1280, 0, 0, 1, 0, 0);
    addv(0, 0, 48'h5280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h1280, 0, 0, 1, 0, 0);
    // 9..15 : FIFO in set 10
    addv(1, 0, 48'h1280, 0, 1, 0, 0, 0);
    addv(0, 0, 48'h2280, 0, 1, 0, 0, 0);
    addv(0, 0, 48'h3280, 0, 1, 0, 0, 0);
    addv(0, 0, 48'h4280, 0, 1, 0, 0, 0);
    addv(0, 0, 48'h1280, 0, 1, 1, 0, 0);
    addv(0, 0, 48'h5280, 0, 1, 0, 0, 0);
    addv(0, 0, 48'h1280, 0, 1, 0, 0, 0);
    // 16..20 : WBWA dirty eviction
    addv(1, 1, 48'h1280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h2280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h3280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h4280, 0, 0, 0, 0, 0);
    addv(0, 0, 48'h5280, 0, 0, 0, 1, 0);
    // 21..24 : WTNA no-allocate and write-through hit
    addv(1, 1, 48'h634600, 1, 0, 0, 0, 1);
    addv(0, 0, 48'h634600, 1, 0, 0, 0, 0);
    addv(0, 0, 48'h634600, 1, 0, 1, 0, 0);
    addv(0, 1, 48'h634600, 1, 0, 1, 0, 1);

    repeat (2) @(negedge clk);

    run_vec(0, 1);
    chk("g0_curr_tag", 64'(curr_tag), 64'h7fff49382);
    chk("g0_num_reads", 64'(num_reads), 64'd2);
    chk("g0_num_read_misses", 64'(num_read_misses), 64'd1);
    chk("g0_num_hits", 64'(num_hits), 64'd1);

    do_reset();
    chk("rst_curr_tag", 64'(curr_tag), 64'd0);
    chk("rst_num_reads", 64'(num_reads), 64'd0);
    chk("rst_num_hits", 64'(num_hits), 64'd0);
    chk("rst_num_read_misses", 64'(num_read_misses), 64'd0);

    run_vec(2, 8);
    chk("lru_num_hits", 64'(num_hits), 64'd2);
    chk("lru_num_read_misses", 64'(num_read_misses), 64'd5);
    chk("lru_num_reads", 64'(num_reads), 64'd7);

    run_vec(9, 15);
    chk("fifo_num_hits", 64'(num_hits), 64'd1);
    chk("fifo_num_read_misses", 64'(num_read_misses), 64'd6);

    run_vec(16, 20);
    chk("wbwa_num_writebacks", 64'(num_writebacks), 64'd1);
    chk("wbwa_num_write_misses", 64'(num_write_misses), 64'd1);
    chk("wbwa_num_writes", 64'(num_writes), 64'd1);
    chk("wbwa_num_reads", 64'(num_reads), 64'd4);

    run_vec(21, 24);
    chk("wtna_num_writes", 64'(num_writes), 64'd2);
    chk("wtna_num_reads", 64'(num_reads), 64'd2);
    chk("wtna_num_write_misses", 64'(num_write_misses), 64'd1);
    chk("wtna_num_read_misses", 64'(num_read_misses), 64'd1);
    chk("wtna_num_hits", 64'(num_hits), 64'd2);
    chk("wtna_num_writebacks", 64'(num_writebacks), 64'd0);

    // Reset pulsed while a read sits in LOOKUP
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 48'h1280; write_policy = 1'b0; replace_policy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("abort_resp_valid_%0d", n), {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
    end
    chk("abort_num_reads", 64'(num_reads), 64'd0);
    chk("abort_num_read_misses", 64'(num_read_misses), 64'd0);
    chk("abort_num_hits", 64'(num_hits), 64'd0);
    issue(1'b0, 48'h1280, 1'b0, 1'b0, h, wb, mw, lat);
    chk("reissue_latency", 64'(lat), 64'd2);
    chk("reissue_hit", {63'd0, h}, 64'd0);
    chk("reissue_num_reads", 64'(num_reads), 64'd1);

    // Saturation on the 4-bit counter instance
    do_reset();
    for (int i = 0; i < 20; i++) issue(1'b0, 48'h1000, 1'b0, 1'b0, h, wb, mw, lat);
    chk("sat_num_reads", 64'(s_reads), 64'd15);
    chk("sat_num_hits", 64'(s_hits), 64'd15);
    chk("sat_num_read_misses", 64'(s_rdm), 64'd1);
    chk("wide_num_reads", 64'(num_reads), 64'd20);
    chk("wide_num_hits", 64'(num_hits), 64'd19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
